// File: rtl/seg7_capture.sv
//-----------------------------------------------------------------------------
// seg7_capture
//
// Recovers hex digit values from a multiplexed, active-low 7-segment display
// bus. Each cycle the segment bus and digit strobe are sampled together. A
// tracker requires a pattern to stay unchanged for STABLE_CYCLES samples
// before the pattern is committed to the digit the strobe selects. Committed
// glyphs are decoded into nibbles, and each digit carries valid/error flags.
// A frame pulse marks the point where all four digits have been committed.
//
// Parameters
//   STABLE_CYCLES  identical samples needed before a commit (2..255)
//
// Ports
//   iCLK         system clock, rising edge
//   iRST_N       asynchronous active-low reset
//   iSEG[6:0]    active-low segments, bit0 = a .. bit6 = g
//   iDIG_SEL[3:0] active-low digit strobe, one bit low selects digit 0..3
//   iCLR         synchronous clear of all captured data
//   oDIGITS[15:0] recovered nibbles, digit n at [4n+3:4n]
//   oVALID[3:0]  digit n last committed a legal hex glyph
//   oERR[3:0]    digit n last committed an illegal pattern
//   oFRAME_DONE  one-cycle pulse when all four digits have been committed
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module seg7_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [6:0]  iSEG,
  input  logic [3:0]  iDIG_SEL,
  input  logic        iCLR,
  output logic [15:0] oDIGITS,
  output logic [3:0]  oVALID,
  output logic [3:0]  oERR,
  output logic        oFRAME_DONE
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Saturating increment for the 8-bit stability counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Returns {legal, nibble}; table entries are written g..a.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1000000: r = {1'b1, 4'h0};
      7'b1111001: r = {1'b1, 4'h1};
      7'b0100100: r = {1'b1, 4'h2};
      7'b0110000: r = {1'b1, 4'h3};
      7'b0011001: r = {1'b1, 4'h4};
      7'b0010010: r = {1'b1, 4'h5};
      7'b0000010: r = {1'b1, 4'h6};
      7'b1111000: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0011000: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b0000011: r = {1'b1, 4'hB};
      7'b1000110: r = {1'b1, 4'hC};
      7'b0100001: r = {1'b1, 4'hD};
      7'b0000110: r = {1'b1, 4'hE};
      7'b0001110: r = {1'b1, 4'hF};
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Returns {one_low, index}; anything but exactly one low bit is rejected.
  function automatic logic [2:0] digit_sel(input logic [3:0] sel);
    logic [2:0] r;
    case (sel)
      4'b1110: r = 3'b1_00;
      4'b1101: r = 3'b1_01;
      4'b1011: r = 3'b1_10;
      4'b0111: r = 3'b1_11;
      default: r = 3'b0_00;
    endcase
    return r;
  endfunction

  // ---- Stage p0: raw bus sample and its one-cycle-older copy ----
  // Both reset to all-ones so the first post-reset sample reads as a change
  // and the strobe decodes as "nothing selected".
  logic [10:0] smp_p0;
  logic [10:0] smp_p1;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      smp_p0 <= '1;
      smp_p1 <= '1;
    end else begin
      smp_p0 <= {iDIG_SEL, iSEG};
      smp_p1 <= smp_p0;
    end
  end

  logic [3:0] sel_p0;
  logic [6:0] seg_p0;
  logic [2:0] dsel_p0;
  logic       vld_p0;
  logic [1:0] idx_p0;

  assign sel_p0  = smp_p0[10:7];
  assign seg_p0  = smp_p0[6:0];
  assign dsel_p0 = digit_sel(sel_p0);
  assign vld_p0  = dsel_p0[2];
  assign idx_p0  = dsel_p0[1:0];

  // ---- Stage p1: stability tracker, decides the commit ----
  state_t     state_q;
  state_t     state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] cnt_inc;
  logic       vld_p1;

  assign cnt_inc = sat_inc(cnt_q);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vld_p1  = 1'b0;
    if (iCLR) begin
      // Clear drops qualification so the pattern on the bus restarts at 1.
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else if (!vld_p0) begin
      state_d = IDLE;
      cnt_d   = 8'd0;
    end else if ((smp_p0 != smp_p1) || (state_q == IDLE)) begin
      // A fresh pattern, or a legal strobe appearing after IDLE, is the
      // first sample of a new qualification run.
      state_d = COUNT;
      cnt_d   = 8'd1;
    end else begin
      case (state_q)
        COUNT: begin
          cnt_d = cnt_inc;
          if (cnt_inc == STABLE_C) begin
            vld_p1  = 1'b1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          state_d = LOCKED;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  logic [4:0] gly_p1;
  logic       legal_p1;
  logic [3:0] nib_p1;
  logic       blank_p1;
  logic [3:0] hit_p1;
  logic [3:0] mask_upd_p1;

  assign gly_p1      = decode_glyph(seg_p0);
  assign legal_p1    = gly_p1[4];
  assign nib_p1      = gly_p1[3:0];
  assign blank_p1    = (seg_p0 == SEG_BLANK);
  assign hit_p1      = 4'b0001 << idx_p0;

  // ---- Stage p2: captured digits, flags and frame tracking ----
  logic [15:0] dig_p2;
  logic [3:0]  valid_p2;
  logic [3:0]  err_p2;
  logic [3:0]  mask_p2;
  logic        frame_p2;

  assign mask_upd_p1 = mask_p2 | hit_p1;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      dig_p2   <= 16'h0000;
      valid_p2 <= 4'b0000;
      err_p2   <= 4'b0000;
      mask_p2  <= 4'b0000;
      frame_p2 <= 1'b0;
    end else begin
      frame_p2 <= 1'b0;
      if (iCLR) begin
        dig_p2   <= 16'h0000;
        valid_p2 <= 4'b0000;
        err_p2   <= 4'b0000;
        mask_p2  <= 4'b0000;
      end else if (vld_p1) begin
        if (legal_p1) begin
          dig_p2[{idx_p0, 2'b00} +: 4] <= nib_p1;
          valid_p2[idx_p0]             <= 1'b1;
          err_p2[idx_p0]               <= 1'b0;
        end else if (blank_p1) begin
          valid_p2[idx_p0] <= 1'b0;
          err_p2[idx_p0]   <= 1'b0;
        end else begin
          valid_p2[idx_p0] <= 1'b0;
          err_p2[idx_p0]   <= 1'b1;
        end
        // The frame pulse and the mask restart land on the same edge as
        // the commit that completes the set.
        if (mask_upd_p1 == 4'b1111) begin
          frame_p2 <= 1'b1;
          mask_p2  <= 4'b0000;
        end else begin
          mask_p2 <= mask_upd_p1;
        end
      end
    end
  end

  assign oDIGITS     = dig_p2;
  assign oVALID      = valid_p2;
  assign oERR        = err_p2;
  assign oFRAME_DONE = frame_p2;

endmodule

// File: tb/tb_seg7_capture.sv
//-----------------------------------------------------------------------------
// tb_seg7_capture
//
// Directed bench for seg7_capture. Stimulus pushes the hand-computed output
// state and the clock count at which it must appear; a monitor pops an entry
// whenever the outputs change or a frame pulse shows, and compares both.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_seg7_capture;

  localparam int SC = 4;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [6:0]  iSEG;
  logic [3:0]  iDIG_SEL;
  logic        iCLR;
  logic [15:0] oDIGITS;
  logic [3:0]  oVALID;
  logic [3:0]  oERR;
  logic        oFRAME_DONE;

  seg7_capture #(.STABLE_CYCLES(SC)) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iSEG        (iSEG),
    .iDIG_SEL    (iDIG_SEL),
    .iCLR        (iCLR),
    .oDIGITS     (oDIGITS),
    .oVALID      (oVALID),
    .oERR        (oERR),
    .oFRAME_DONE (oFRAME_DONE)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [15:0] dig;
    logic [3:0]  vld;
    logic [3:0]  err;
    logic        frm;
    int          at;
  } exp_t;

  exp_t sb[$];
  bit   mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic [15:0] d, input logic [3:0] v,
                      input logic [3:0] e, input logic f, input int at);
    exp_t x;
    x.tag = tag;
    x.dig = d;
    x.vld = v;
    x.err = e;
    x.frm = f;
    x.at  = at;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic [6:0] g);
    iDIG_SEL = s;
    iSEG     = g;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    logic [23:0] last;
    logic [23:0] cur;
    exp_t        x;
    last = '0;
    forever begin
      @(negedge iCLK);
      cur = {oDIGITS, oVALID, oERR};
      if (!iRST_N || !mon_en) begin
        last = cur;
      end else if ((cur !== last) || (oFRAME_DONE !== 1'b0)) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_update: got digits=%h valid=%b err=%b frame=%b at cycle %0d, expected no update",
                   oDIGITS, oVALID, oERR, oFRAME_DONE, cyc);
        end else begin
          x = sb.pop_front();
          chk($sformatf("%s_value", x.tag), {7'd0, oDIGITS, oVALID, oERR, oFRAME_DONE},
              {7'd0, x.dig, x.vld, x.err, x.frm});
          chk($sformatf("%s_cycle", x.tag), cyc, x.at);
        end
        last = cur;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    iRST_N = 1'b0;
    iCLR   = 1'b0;
    drive(4'b1111, 7'h7F);
    tick(2);
    chk("reset_digits", oDIGITS, 16'h0000);
    chk("reset_valid", oVALID, 4'b0000);
    chk("reset_err", oERR, 4'b0000);
    chk("reset_frame", oFRAME_DONE, 1'b0);

    // Single stable pattern held 10 cycles: one update at the 5th edge.
    iRST_N = 1'b1;
    mon_en = 1'b1;
    k = cyc;
    drive(4'b1110, 7'b0100100);
    push("hold_two", 16'h0002, 4'b0001, 4'b0000, 1'b0, k + 5);
    tick(10);

    // Held one cycle short of qualification, then the strobe goes idle.
    drive(4'b1101, 7'b1111001);
    tick(3);
    drive(4'b1111, 7'b1111111);
    tick(8);

    // Two strobe bits low: never a commit.
    drive(4'b1100, 7'b0100100);
    tick(20);

    // Clear wipes the earlier capture.
    k = cyc;
    iCLR = 1'b1;
    push("clear", 16'h0000, 4'b0000, 4'b0000, 1'b0, k + 1);
    tick(1);
    iCLR = 1'b0;

    // Full frame: 1, A, blank, illegal.
    k = cyc;
    drive(4'b1110, 7'b1111001);
    push("frame_d0", 16'h0001, 4'b0001, 4'b0000, 1'b0, k + 5);
    tick(6);
    k = cyc;
    drive(4'b1101, 7'b0001000);
    push("frame_d1", 16'h00A1, 4'b0011, 4'b0000, 1'b0, k + 5);
    tick(6);
    drive(4'b1011, 7'b1111111);
    tick(6);
    k = cyc;
    drive(4'b0111, 7'b0110110);
    push("frame_d3", 16'h00A1, 4'b0011, 4'b1000, 1'b1, k + 5);
    tick(6);

    // Clear landing in the commit cycle, then requalification.
    k = cyc;
    drive(4'b1110, 7'b1111000);
    push("clr_commit", 16'h0000, 4'b0000, 4'b0000, 1'b0, k + 5);
    push("recommit", 16'h0007, 4'b0001, 4'b0000, 1'b0, k + 9);
    tick(4);
    iCLR = 1'b1;
    tick(1);
    iCLR = 1'b0;
    tick(6);

    // Reset pulse in mid-count.
    k = cyc;
    drive(4'b1101, 7'b0100100);
    tick(3);
    iRST_N = 1'b0;
    #1;
    chk("midreset_digits", oDIGITS, 16'h0000);
    chk("midreset_valid", oVALID, 4'b0000);
    chk("midreset_err", oERR, 4'b0000);
    chk("midreset_frame", oFRAME_DONE, 1'b0);
    #4;
    iRST_N = 1'b1;
    push("post_reset", 16'h0020, 4'b0010, 4'b0000, 1'b0, k + 8);
    tick(6);

    // Blank, illegal and legal on the same digit.
    k = cyc;
    drive(4'b1101, 7'b1111111);
    push("blank_d1", 16'h0020, 4'b0000, 4'b0000, 1'b0, k + 5);
    tick(6);
    k = cyc;
    drive(4'b1101, 7'b0101010);
    push("illegal_d1", 16'h0020, 4'b0000, 4'b0010, 1'b0, k + 5);
    tick(6);
    k = cyc;
    drive(4'b1101, 7'b0001110);
    push("hexf_d1", 16'h00F0, 4'b0010, 4'b0000, 1'b0, k + 5);
    tick(6);

    tick(4);
    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
